sram_rw_ctrl: RTL and testbench
===============================

Name: sram_rw_ctrl

Overview:
- Parametrised external asynchronous-SRAM access controller; successor to the fixed 2-wait read-only instruction-ROM reader.
- Adds configurable address/data width, programmable wait states, writes with byte enables, write-to-read bus turnaround, and a req/ready + rsp_valid handshake with back-to-back issue.
- Sits between the IF/MEM stage bus logic and the board SRAM pins; one instance per SRAM bank.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 32, data width; must be a multiple of 8
BE_W, DATA_W/8, byte-enable width (derived, do not override)
WAIT_CYC, 2, cycles SRAM strobes held per access; legal range 1..15
TURN_CYC, 1, idle cycles inserted between a write and a following read; legal range 0..3

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  1  access request
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
req_be  in  BE_W  byte enables, active-high (writes only)
req_ready  out  1  controller accepts req this cycle
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  DATA_W  registered read data
busy  out  1  state != IDLE
sram_addr  out  ADDR_W  SRAM address pins
sram_wdata  out  DATA_W  data driven to SRAM
sram_wdata_oe  out  1  tri-state enable for sram_wdata
sram_rdata  in  DATA_W  data from SRAM
sram_ce_n  out  1  chip enable, active-low
sram_oe_n  out  1  output enable, active-low
sram_we_n  out  1  write enable, active-low
sram_be_n  out  BE_W  byte lanes, active-low

Behaviour:
- Reset (rst=0, async): state IDLE; ce_n=oe_n=we_n=1; be_n=all 1; sram_addr=0; sram_wdata=0; wdata_oe=0; rsp_valid=0; rsp_rdata=0; busy=0; req_ready=0 while rst=0.
- All SRAM pin outputs and rsp_* are registered; req_ready and busy are combinational from state.
- States: IDLE, ACCESS, DONE, TURN.
- req_ready=1 in IDLE and DONE, 0 in ACCESS and TURN. Accept = req & req_ready; accept latches we/addr/wdata/be.
- IDLE: on accept -> ACCESS, counter=0.
- ACCESS: ce_n=0, sram_addr=latched addr. Read: oe_n=0, we_n=1, be_n=all 0, wdata_oe=0. Write: oe_n=1, we_n=0, be_n=~latched be, wdata_oe=1. Counter increments each cycle. On the clock edge ending cycle WAIT_CYC-1: read captures sram_rdata into rsp_rdata; -> DONE.
- DONE (exactly 1 cycle): rsp_valid=1; ce_n=oe_n=we_n=1; be_n=all 1. After a write, wdata_oe stays 1 and sram_wdata is held (data hold time); it drops on leaving DONE.
- DONE transitions: no accept -> IDLE. Accept, and (previous op was a write, new op is a read, TURN_CYC>0) -> TURN. Any other accept -> ACCESS.
- TURN: all strobes high, wdata_oe=0; holds for TURN_CYC cycles -> ACCESS with the already-latched request.
- Latency: request accepted at edge k -> ACCESS in cycles k+1..k+WAIT_CYC -> rsp_valid in cycle k+WAIT_CYC+1. Back-to-back throughput is one access per WAIT_CYC+1 cycles.
- Write response: rsp_valid pulses; rsp_rdata unchanged.
- req_be=0 on a write: the access still runs, we_n asserts, be_n=all 1 (no bytes written), and rsp_valid is still returned.
- Reset asserted mid-access: strobes deassert immediately (async); the pending access is dropped and no rsp_valid is issued after reset release.
- Request inputs are sampled only at accept; changes while req_ready=0 are ignored.

Test Plan:
- WAIT_CYC=2: read addr 0x00010, SRAM model returns 0xDEADBEEF -> oe_n=0 for 2 cycles; rsp_valid pulses 3 cycles after accept; rsp_rdata=0xDEADBEEF.
- Four back-to-back reads with req held high (addrs 0..3) -> rsp_valid every 3 cycles; ce_n high exactly 1 cycle (DONE) between accesses; data in address order.
- Write 0x12345678 to 0x00020 with be=4'b0011, then read 0x00020 with TURN_CYC=1 -> we_n low 2 cycles with be_n=4'b1100; wdata_oe high through DONE; 1 TURN cycle with wdata_oe=0; read returns 0xXXXX5678 with upper bytes preserved.
- WAIT_CYC=1, TURN_CYC=0: write then read -> write-read sequence completes in 4 cycles with no TURN state; rsp_valid pulses twice.
- rst pulsed low during ACCESS cycle 1 of a read -> ce_n/oe_n go high asynchronously; no rsp_valid; req_ready=0 during reset and =1 in IDLE after release.
- req held low for 20 cycles after reset -> busy=0, all strobes high, wdata_oe=0 throughout.

Source files
------------

// File: rtl/sram_rw_ctrl.sv
// Asynchronous-SRAM access controller: programmable wait states, byte-enable writes,
// write-to-read turnaround and a req/ready + rsp_valid handshake with back-to-back issue.
module sram_rw_ctrl #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BE_W     = DATA_W / 8,
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  output logic              sram_wdata_oe,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [BE_W-1:0]   sram_be_n
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, TURN} state_e;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_we, w_we_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
  logic [BE_W-1:0]     r_be, w_be_nxt;

  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic [ADDR_W-1:0]   r_sram_addr, w_sram_addr_nxt;
  logic [DATA_W-1:0]   r_sram_wdata, w_sram_wdata_nxt;
  logic                r_wdata_oe, w_wdata_oe_nxt;
  logic                r_ce_n, w_ce_n_nxt;
  logic                r_oe_n, w_oe_n_nxt;
  logic                r_we_n, w_we_n_nxt;
  logic [BE_W-1:0]     r_be_n, w_be_n_nxt;

  logic                w_accept;

  assign req_ready = rst & ((r_state == IDLE) | (r_state == DONE));
  assign busy      = (r_state != IDLE);
  assign w_accept  = req & req_ready;

  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign sram_addr     = r_sram_addr;
  assign sram_wdata    = r_sram_wdata;
  assign sram_wdata_oe = r_wdata_oe;
  assign sram_ce_n     = r_ce_n;
  assign sram_oe_n     = r_oe_n;
  assign sram_we_n     = r_we_n;
  assign sram_be_n     = r_be_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_wdata_oe   <= 1'b0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_be_n       <= '1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_be         <= w_be_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
      r_sram_addr  <= w_sram_addr_nxt;
      r_sram_wdata <= w_sram_wdata_nxt;
      r_wdata_oe   <= w_wdata_oe_nxt;
      r_ce_n       <= w_ce_n_nxt;
      r_oe_n       <= w_oe_n_nxt;
      r_we_n       <= w_we_n_nxt;
      r_be_n       <= w_be_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_be_nxt         = r_be;
    w_rsp_valid_nxt  = 1'b0;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    w_sram_addr_nxt  = r_sram_addr;
    w_sram_wdata_nxt = r_sram_wdata;
    w_wdata_oe_nxt   = 1'b0;
    w_ce_n_nxt       = 1'b1;
    w_oe_n_nxt       = 1'b1;
    w_we_n_nxt       = 1'b1;
    w_be_n_nxt       = '1;

    if (w_accept) begin
      w_we_nxt    = req_we;
      w_addr_nxt  = req_addr;
      w_wdata_nxt = req_wdata;
      w_be_nxt    = req_be;
    end

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        if (r_cnt == CNT_W'(WAIT_CYC - 1)) begin
          w_state_nxt = DONE;
          if (!r_we) w_rsp_rdata_nxt = sram_rdata;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      DONE: begin
        w_cnt_nxt = '0;
        if (!w_accept) begin
          w_state_nxt = IDLE;
        end else if (r_we && !req_we && (TURN_CYC > 0)) begin
          w_state_nxt = TURN;
        end else begin
          w_state_nxt = ACCESS;
        end
      end
      TURN: begin
        if (r_cnt == CNT_W'(TURN_CYC - 1)) begin
          w_state_nxt = ACCESS;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Pin values are registered, so they follow the state being entered.
    case (w_state_nxt)
      ACCESS: begin
        w_ce_n_nxt      = 1'b0;
        w_sram_addr_nxt = w_addr_nxt;
        if (w_we_nxt) begin
          w_we_n_nxt       = 1'b0;
          w_be_n_nxt       = ~w_be_nxt;
          w_wdata_oe_nxt   = 1'b1;
          w_sram_wdata_nxt = w_wdata_nxt;
        end else begin
          w_oe_n_nxt = 1'b0;
          w_be_n_nxt = '0;
        end
      end
      DONE: begin
        w_rsp_valid_nxt = 1'b1;
        w_wdata_oe_nxt  = w_we_nxt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_rw_ctrl.sv
// Bench for sram_rw_ctrl: two instances (WAIT=2/TURN=1 and WAIT=1/TURN=0) checked every
// cycle against a timeline model of each access, plus hand-computed literal expectations.
module tb_sram_rw_ctrl;

  localparam int WA = 2, TA = 1, WB = 1, TB = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_a, we_a, req_b, we_b;
  logic [19:0] addr_a, addr_b;
  logic [31:0] wdata_a, wdata_b;
  logic [3:0]  be_a, be_b;

  logic        ready_a, rv_a, busy_a, soe_a, ce_a, oe_a, wen_a;
  logic        ready_b, rv_b, busy_b, soe_b, ce_b, oe_b, wen_b;
  logic [31:0] rdata_a, swd_a, srd_a, rdata_b, swd_b, srd_b;
  logic [19:0] saddr_a, saddr_b;
  logic [3:0]  ben_a, ben_b;

  sram_rw_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYC(WA), .TURN_CYC(TA)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .req_we(we_a), .req_addr(addr_a),
    .req_wdata(wdata_a), .req_be(be_a), .req_ready(ready_a), .rsp_valid(rv_a),
    .rsp_rdata(rdata_a), .busy(busy_a), .sram_addr(saddr_a), .sram_wdata(swd_a),
    .sram_wdata_oe(soe_a), .sram_rdata(srd_a), .sram_ce_n(ce_a), .sram_oe_n(oe_a),
    .sram_we_n(wen_a), .sram_be_n(ben_a));

  sram_rw_ctrl #(.ADDR_W(20), .DATA_W(32), .WAIT_CYC(WB), .TURN_CYC(TB)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .req_we(we_b), .req_addr(addr_b),
    .req_wdata(wdata_b), .req_be(be_b), .req_ready(ready_b), .rsp_valid(rv_b),
    .rsp_rdata(rdata_b), .busy(busy_b), .sram_addr(saddr_b), .sram_wdata(swd_b),
    .sram_wdata_oe(soe_b), .sram_rdata(srd_b), .sram_ce_n(ce_b), .sram_oe_n(oe_b),
    .sram_we_n(wen_b), .sram_be_n(ben_b));

  // Power-up SRAM contents; 0x10 holds the test word.
  function automatic logic [31:0] pat(input logic [19:0] a);
    return (a == 20'h10) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] lane_on);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (lane_on[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural SRAMs, one per instance
  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [63:0] wr_a = '0;
  logic [63:0] wr_b = '0;

  assign srd_a = (!ce_a && !oe_a) ? (wr_a[saddr_a[5:0]] ? mem_a[saddr_a[5:0]] : pat(saddr_a)) : 32'h0;
  assign srd_b = (!ce_b && !oe_b) ? (wr_b[saddr_b[5:0]] ? mem_b[saddr_b[5:0]] : pat(saddr_b)) : 32'h0;

  always @(posedge clk) begin
    if (ce_a === 1'b0 && wen_a === 1'b0) begin
      mem_a[saddr_a[5:0]] <= merge(wr_a[saddr_a[5:0]] ? mem_a[saddr_a[5:0]] : pat(saddr_a), swd_a, ~ben_a);
      wr_a[saddr_a[5:0]]  <= 1'b1;
    end
    if (ce_b === 1'b0 && wen_b === 1'b0) begin
      mem_b[saddr_b[5:0]] <= merge(wr_b[saddr_b[5:0]] ? mem_b[saddr_b[5:0]] : pat(saddr_b), swd_b, ~ben_b);
      wr_b[saddr_b[5:0]]  <= 1'b1;
    end
  end

  typedef struct {
    logic ready, busy, rv, oe, ce_n, oe_n, we_n;
    logic [31:0] rdata, wd;
    logic [19:0] addr;
    logic [3:0]  be_n;
  } snap_t;

  int n_vec, n_err, t;

  // Timeline model: accept cycle, first access cycle, done cycle of the latest access
  bit          m_has [2];
  int          m_ta [2], m_ts [2], m_td [2];
  bit          m_we [2];
  logic [19:0] m_addr [2], m_paddr [2];
  logic [31:0] m_wdata [2], m_rd [2], m_rdata [2];
  logic [3:0]  m_be [2];
  logic [31:0] mm [2][64];
  bit          mw [2][64];

  int          rvt0[$], rvt1[$];
  logic [31:0] rvd0[$], rvd1[$];
  int          n_oel [2], n_wel [2];

  task automatic chk(input int i, input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] cycle %0d: got %h expected %h", nm, i, t, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(input int i, input logic [19:0] a);
    return mw[i][a[5:0]] ? mm[i][a[5:0]] : pat(a);
  endfunction

  function automatic bit mready(input int i);
    return (rst === 1'b1) && !(m_has[i] && t > m_ta[i] && t < m_td[i]);
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_has[i] = 0; m_rdata[i] = '0; m_paddr[i] = '0;
    end
  endtask

  task automatic sample(input int i, output snap_t s);
    if (i == 0) begin
      s.ready = ready_a; s.busy = busy_a; s.rv = rv_a; s.oe = soe_a; s.ce_n = ce_a;
      s.oe_n = oe_a; s.we_n = wen_a; s.rdata = rdata_a; s.wd = swd_a; s.addr = saddr_a; s.be_n = ben_a;
    end else begin
      s.ready = ready_b; s.busy = busy_b; s.rv = rv_b; s.oe = soe_b; s.ce_n = ce_b;
      s.oe_n = oe_b; s.we_n = wen_b; s.rdata = rdata_b; s.wd = swd_b; s.addr = saddr_b; s.be_n = ben_b;
    end
  endtask

  task automatic compare(input int i);
    snap_t s;
    bit acc, dn, bsy;
    logic [3:0] ebe;
    sample(i, s);
    if (s.rv === 1'b1) begin
      if (i == 0) begin rvt0.push_back(t); rvd0.push_back(s.rdata); end
      else begin rvt1.push_back(t); rvd1.push_back(s.rdata); end
    end
    if (s.oe_n === 1'b0) n_oel[i]++;
    if (s.we_n === 1'b0) n_wel[i]++;
    if (rst !== 1'b1) begin
      chk(i, "rst_ready", 32'(s.ready), 0);  chk(i, "rst_busy", 32'(s.busy), 0);
      chk(i, "rst_rv", 32'(s.rv), 0);        chk(i, "rst_rdata", s.rdata, 0);
      chk(i, "rst_addr", 32'(s.addr), 0);    chk(i, "rst_wdata", s.wd, 0);
      chk(i, "rst_oe", 32'(s.oe), 0);        chk(i, "rst_ce_n", 32'(s.ce_n), 1);
      chk(i, "rst_oe_n", 32'(s.oe_n), 1);    chk(i, "rst_we_n", 32'(s.we_n), 1);
      chk(i, "rst_be_n", 32'(s.be_n), 32'hF);
      return;
    end
    acc = m_has[i] && t >= m_ts[i] && t < m_td[i];
    dn  = m_has[i] && t == m_td[i];
    bsy = m_has[i] && t > m_ta[i] && t <= m_td[i];
    if (dn && !m_we[i]) m_rdata[i] = m_rd[i];
    if (acc) m_paddr[i] = m_addr[i];
    ebe = !acc ? 4'hF : (m_we[i] ? ~m_be[i] : 4'h0);
    chk(i, "ready", 32'(s.ready), 32'(!bsy || dn));
    chk(i, "busy", 32'(s.busy), 32'(bsy));
    chk(i, "rsp_valid", 32'(s.rv), 32'(dn));
    chk(i, "rsp_rdata", s.rdata, m_rdata[i]);
    chk(i, "sram_addr", 32'(s.addr), 32'(m_paddr[i]));
    chk(i, "ce_n", 32'(s.ce_n), 32'(!acc));
    chk(i, "oe_n", 32'(s.oe_n), 32'(!(acc && !m_we[i])));
    chk(i, "we_n", 32'(s.we_n), 32'(!(acc && m_we[i])));
    chk(i, "be_n", 32'(s.be_n), 32'(ebe));
    chk(i, "wdata_oe", 32'(s.oe), 32'((acc || dn) && m_we[i]));
    if ((acc || dn) && m_we[i]) chk(i, "sram_wdata", s.wd, m_wdata[i]);
  endtask

  task automatic maccept(input int i);
    bit rq, we, turn;
    logic [19:0] a;
    logic [31:0] d;
    logic [3:0] be;
    int wc, tc;
    if (i == 0) begin rq = req_a; we = we_a; a = addr_a; d = wdata_a; be = be_a; wc = WA; tc = TA; end
    else begin rq = req_b; we = we_b; a = addr_b; d = wdata_b; be = be_b; wc = WB; tc = TB; end
    if (!(rq && mready(i))) return;
    turn = m_has[i] && t == m_td[i] && m_we[i] && !we && tc > 0;
    m_ta[i] = t;
    m_ts[i] = t + 1 + (turn ? tc : 0);
    m_td[i] = m_ts[i] + wc;
    m_we[i] = we; m_addr[i] = a; m_wdata[i] = d; m_be[i] = be; m_has[i] = 1;
    if (we) begin
      mm[i][a[5:0]] = merge(mread(i, a), d, be);
      mw[i][a[5:0]] = 1;
    end else begin
      m_rd[i] = mread(i, a);
    end
  endtask

  task automatic cyc_go();
    maccept(0); maccept(1);
    @(posedge clk);
    @(negedge clk);
    t++;
    compare(0); compare(1);
  endtask

  task automatic drv(input int i, input bit rq, input bit we, input logic [19:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    if (i == 0) begin req_a = rq; we_a = we; addr_a = a; wdata_a = d; be_a = be; end
    else begin req_b = rq; we_b = we; addr_b = a; wdata_b = d; be_b = be; end
  endtask

  // Holds the request until the model says it is accepted; req stays high afterwards.
  task automatic issue(input int i, input bit we, input logic [19:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    bit acc;
    acc = 0;
    drv(i, 1'b1, we, a, d, be);
    for (int c = 0; c < 20 && !acc; c++) begin
      acc = mready(i);
      cyc_go();
    end
    chk(i, "issue_accepted", 32'(acc), 1);
  endtask

  initial begin
    int tk, base, base_oe, base_we, n;
    n_vec = 0; n_err = 0; t = 0;
    for (int i = 0; i < 2; i++) begin
      n_oel[i] = 0; n_wel[i] = 0;
      for (int a = 0; a < 64; a++) begin mw[i][a] = 0; mm[i][a] = '0; end
    end
    drv(0, 0, 0, '0, '0, '0); drv(1, 0, 0, '0, '0, '0);
    rst = 1'b1;
    #2 rst = 1'b0;
    mreset();
    @(negedge clk);
    compare(0); compare(1);
    repeat (2) cyc_go();
    rst = 1'b1;

    // Idle after reset
    repeat (20) cyc_go();
    chk(0, "idle_busy", 32'(busy_a), 0);
    chk(0, "idle_oe_cnt", 32'(n_oel[0]), 0);

    // Single read of 0x10
    base = rvt0.size(); base_oe = n_oel[0]; tk = t;
    issue(0, 1'b0, 20'h10, '0, '0);
    drv(0, 0, 0, '0, '0, '0);
    repeat (5) cyc_go();
    chk(0, "rd_rsp_cnt", 32'(rvt0.size() - base), 1);
    chk(0, "rd_latency", 32'(rvt0[base]), 32'(tk + 3));
    chk(0, "rd_data", rvd0[base], 32'hDEADBEEF);
    chk(0, "rd_oe_cycles", 32'(n_oel[0] - base_oe), 2);

    // Four back-to-back reads, addresses 0..3
    base = rvt0.size(); n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      drv(0, 1'b1, 1'b0, 20'(n), '0, '0);
      if (mready(0)) n++;
      cyc_go();
    end
    drv(0, 0, 0, '0, '0, '0);
    repeat (5) cyc_go();
    chk(0, "b2b_cnt", 32'(rvt0.size() - base), 4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < rvt0.size()) begin
        chk(0, "b2b_data", rvd0[base + k], 32'hC0DE0000 + 32'(k));
        if (k > 0) chk(0, "b2b_spacing", 32'(rvt0[base + k] - rvt0[base + k - 1]), 3);
      end
    end

    // Partial write then read of the same word, with turnaround
    base = rvt0.size(); base_we = n_wel[0];
    issue(0, 1'b1, 20'h20, 32'h12345678, 4'b0011);
    issue(0, 1'b0, 20'h20, '0, '0);
    drv(0, 0, 0, '0, '0, '0);
    repeat (5) cyc_go();
    chk(0, "wr_rd_cnt", 32'(rvt0.size() - base), 2);
    if (rvt0.size() >= base + 2) begin
      chk(0, "wr_rd_spacing", 32'(rvt0[base + 1] - rvt0[base]), 4);
      chk(0, "wr_rd_data", rvd0[base + 1], 32'hC0DE5678);
    end
    chk(0, "wr_we_cycles", 32'(n_wel[0] - base_we), 2);

    // WAIT=1/TURN=0 instance: write/read pair, then a zero-byte-enable write
    base = rvt1.size(); tk = t;
    issue(1, 1'b1, 20'h5, 32'hA5A5A5A5, 4'hF);
    issue(1, 1'b0, 20'h5, '0, '0);
    issue(1, 1'b1, 20'h6, 32'hFFFFFFFF, 4'h0);
    issue(1, 1'b0, 20'h6, '0, '0);
    drv(1, 0, 0, '0, '0, '0);
    repeat (4) cyc_go();
    chk(1, "b_rsp_cnt", 32'(rvt1.size() - base), 4);
    if (rvt1.size() >= base + 4) begin
      chk(1, "b_wr_rsp", 32'(rvt1[base]), 32'(tk + 2));
      chk(1, "b_rd_rsp", 32'(rvt1[base + 1]), 32'(tk + 4));
      chk(1, "b_rd_data", rvd1[base + 1], 32'hA5A5A5A5);
      chk(1, "b_be0_data", rvd1[base + 3], 32'hC0DE0006);
    end

    // Reset asserted in the second access cycle of a read
    base = rvt0.size();
    issue(0, 1'b0, 20'h1, '0, '0);
    drv(0, 0, 0, '0, '0, '0);
    cyc_go();
    rst = 1'b0;
    #1;
    chk(0, "arst_ce_n", 32'(ce_a), 1);
    chk(0, "arst_oe_n", 32'(oe_a), 1);
    chk(0, "arst_ready", 32'(ready_a), 0);
    mreset();
    repeat (3) cyc_go();
    rst = 1'b1;
    repeat (6) cyc_go();
    chk(0, "arst_no_rsp", 32'(rvt0.size() - base), 0);
    chk(0, "arst_ready_after", 32'(ready_a), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
